ram_loader: RTL and testbench

//  Write-side companion to the switch-addressed ROM/RAM display path. Captures operator data

---
 rtl/ram_loader_pkg.sv | 6 +
 rtl/ram_loader_key_sync.sv | 18 +
 rtl/ram_loader.sv | 98 +++++++++
 tb/tb_ram_loader.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: state encoding and default widths shared by the RAM loader
package ram_loader_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 10;
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/ram_loader_key_sync.sv
// key_edge_sync: 2-FF synchroniser plus falling-edge detector for an active-low key
//   CLOCK_50 in  system clock
//   RESET_N  in  async active-low reset; flops preset to 1 (key released)
//   key      in  raw active-low pushbutton
//   pulse    out one-cycle pulse per press
module key_edge_sync (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic key,
    output logic pulse
);
    logic s1, s2, s3;
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) {s1, s2, s3} <= 3'b111;
        else          {s1, s2, s3} <= {key, s1, s2};
    end
    assign pulse = s3 & ~s2;
endmodule

// File: rtl/ram_loader.sv
// ram_loader: captures switch data into a RAM write port, single writes or full ramp fill
//   CLOCK_50 in  clock            RESET_N in  async active-low reset
//   SW       in  single-write data KEY1/KEY2 in active-low single-write / fill keys
//   wr_en/wr_addr/wr_data out RAM write port (registered, addr/data held when idle)
//   busy out high during fill      done out one-cycle pulse after last fill write
//   ptr  out next single-write address
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] SW,
    input  logic              KEY1,
    input  logic              KEY2,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ptr
);
    state_t state, state_n;
    logic [ADDR_W-1:0] fa, fa_n, ptr_n, wr_addr_n;
    logic [DATA_W-1:0] wr_data_n;
    logic wr_en_n, busy_n, done_n, wr_p, fill_p;

    key_edge_sync u_k1 (.CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .key(KEY1), .pulse(wr_p));
    key_edge_sync u_k2 (.CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .key(KEY2), .pulse(fill_p));

    // Word 0 is issued on the transition into FILL so the fill has no gap;
    // fa then holds the next address to write.
    always_comb begin
        state_n   = state;
        fa_n      = fa;
        ptr_n     = ptr;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (fill_p) begin
                    state_n   = FILL;
                    wr_en_n   = 1'b1;
                    wr_addr_n = '0;
                    wr_data_n = '0;
                    busy_n    = 1'b1;
                    fa_n      = ADDR_W'(1);
                end else if (wr_p) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = ptr;
                    wr_data_n = SW;
                    ptr_n     = ptr + ADDR_W'(1);
                end
            end
            FILL: begin
                wr_en_n   = 1'b1;
                wr_addr_n = fa;
                wr_data_n = DATA_W'(fa);
                busy_n    = 1'b1;
                fa_n      = fa + ADDR_W'(1);
                state_n   = &fa ? DONE : FILL;
            end
            DONE: begin
                done_n  = 1'b1;
                ptr_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            fa      <= '0;
            ptr     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            fa      <= fa_n;
            ptr     <= ptr_n;
            wr_en   <= wr_en_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: scoreboard bench for ram_loader single writes, wrap, fill, collisions and reset
module tb_ram_loader;
    localparam int DEPTH = 1024;
    logic       CLOCK_50, RESET_N, KEY1, KEY2;
    logic [9:0] SW;
    logic       wr_en, busy, done;
    logic [9:0] wr_addr, wr_data, ptr;
    logic [19:0] exp_q[$];
    logic [9:0]  exp_ptr;
    logic        mon_off;
    int          n_chk, n_fail;

    ram_loader #(.ADDR_W(10), .DATA_W(10)) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .SW(SW), .KEY1(KEY1), .KEY2(KEY2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .ptr(ptr)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (RESET_N && wr_en && !mon_off) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%h expected no write at %0t", wr_addr, wr_data, $time);
            end else begin
                check("write_addr_data", {12'd0, wr_addr, wr_data}, {12'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic press1(input logic [9:0] d);
        SW = d;
        exp_q.push_back({exp_ptr, d});
        exp_ptr++;
        @(negedge CLOCK_50) KEY1 = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        KEY1 = 1'b1;
        repeat (3) @(negedge CLOCK_50);
    endtask

    task automatic run_fill(input bit with_k1, input bit k1_mid);
        int nb;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({10'(i), 10'(i)});
        @(negedge CLOCK_50);
        KEY2 = 1'b0;
        if (with_k1) KEY1 = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("fill_busy_latency", busy, 1);
        KEY2 = 1'b1;
        KEY1 = 1'b1;
        nb = 0;
        while (busy && nb < 2000) begin
            if (k1_mid && nb == 100) KEY1 = 1'b0;
            if (k1_mid && nb == 105) KEY1 = 1'b1;
            nb++;
            @(negedge CLOCK_50);
        end
        check("fill_busy_cycles", nb, DEPTH);
        check("fill_done_pulse", {done, wr_en}, 2'b10);
        @(negedge CLOCK_50);
        check("fill_done_once", done, 0);
        repeat (20) @(negedge CLOCK_50);
        check("fill_ptr_zero", ptr, 0);
        check("fill_queue_drained", exp_q.size(), 0);
        exp_ptr = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_fail = 0; exp_ptr = '0; mon_off = 1'b0;
        RESET_N = 1'b0; KEY1 = 1'b1; KEY2 = 1'b1; SW = '0;
        repeat (3) @(negedge CLOCK_50);
        check("reset_wr_en", wr_en, 0);
        check("reset_wr_addr", wr_addr, 0);
        check("reset_wr_data", wr_data, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ptr", ptr, 0);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLOCK_50);

        SW = 10'h2A5;
        exp_q.push_back({10'd0, 10'h2A5});
        exp_ptr = 10'd1;
        KEY1 = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        check("single_not_before_e3", wr_en, 0);
        @(negedge CLOCK_50);
        check("single_at_e3", wr_en, 1);
        check("single_addr", wr_addr, 0);
        check("single_data", wr_data, 10'h2A5);
        @(negedge CLOCK_50);
        check("single_one_cycle", wr_en, 0);
        @(negedge CLOCK_50);
        KEY1 = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("single_ptr", ptr, 1);
        check("single_held_addr", wr_addr, 0);

        while (exp_ptr != 10'd1023) press1(exp_ptr ^ 10'h155);
        check("wrap_ptr_1023", ptr, 10'd1023);
        press1(10'h3C3);
        check("wrap_held_addr", wr_addr, 10'd1023);
        check("wrap_ptr_zero", ptr, 0);
        check("wrap_queue_drained", exp_q.size(), 0);

        run_fill(1'b0, 1'b0);
        press1(10'h011);
        press1(10'h022);
        check("pre_collision_ptr", ptr, 2);
        run_fill(1'b1, 1'b0);
        run_fill(1'b0, 1'b1);

        mon_off = 1'b1;
        @(negedge CLOCK_50) KEY2 = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        KEY2 = 1'b1;
        for (int i = 0; i < 2000 && !(busy && wr_addr == 10'd300); i++) @(negedge CLOCK_50);
        check("midfill_reach_300", wr_addr, 10'd300);
        #2 RESET_N = 1'b0;
        #1;
        check("midfill_rst_wr_en", wr_en, 0);
        check("midfill_rst_busy", busy, 0);
        check("midfill_rst_addr", wr_addr, 0);
        repeat (2) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        mon_off = 1'b0;
        repeat (40) @(negedge CLOCK_50);
        check("post_rst_busy", busy, 0);
        check("post_rst_ptr", ptr, 0);
        exp_ptr = '0;
        press1(10'h1E7);
        check("post_rst_ptr_one", ptr, 1);
        check("final_queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
